// File: rtl/fma_dot_sequencer.sv
// Sequences a dot-product job through an external FMA unit.
// Ports: clk/rst, job start/len/bias, x and w operand streams, FMA operands/controls, result stream, count.
module fma_dot_sequencer #(
  parameter int WIDTH    = 16,
  parameter int LEN_BITS = 8
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                start_in,
  input  logic [LEN_BITS-1:0] len_in,
  input  logic [WIDTH-1:0]    bias_in,
  output logic                busy_out,
  input  logic [WIDTH-1:0]    x_in,
  input  logic                x_valid_in,
  output logic                x_ready_out,
  input  logic [WIDTH-1:0]    w_in,
  input  logic                w_valid_in,
  output logic                w_ready_out,
  output logic [WIDTH-1:0]    fma_a_out,
  output logic [WIDTH-1:0]    fma_b_out,
  output logic [WIDTH-1:0]    fma_c_out,
  output logic                fma_a_valid_out,
  output logic                fma_b_valid_out,
  output logic                fma_c_valid_out,
  output logic                fma_compute_out,
  input  logic [WIDTH-1:0]    fma_out_in,
  output logic [WIDTH-1:0]    result_out,
  output logic                result_valid_out,
  input  logic                result_ready_in,
  output logic [LEN_BITS-1:0] count_out
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SETTLE,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [LEN_BITS-1:0] len_q;
  logic [LEN_BITS-1:0] count_q;
  logic [WIDTH-1:0]    bias_q;
  logic [WIDTH-1:0]    result_q;
  logic                first_q;
  logic                fire;
  logic                last;

  // A pair is only taken when both streams offer at once.
  assign fire = (state == ACCUM) & x_valid_in & w_valid_in;
  assign last = (count_q == len_q - LEN_BITS'(1));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start_in) begin
          if (len_in != '0) state_nx = ACCUM;
          else              state_nx = DONE;
        end
      end
      ACCUM: begin
        if (fire && last) state_nx = SETTLE;
      end
      SETTLE: state_nx = DONE;
      DONE: begin
        if (result_ready_in) state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      len_q    <= '0;
      count_q  <= '0;
      bias_q   <= '0;
      result_q <= '0;
      first_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_in) begin
            len_q   <= len_in;
            bias_q  <= bias_in;
            count_q <= '0;
            first_q <= 1'b1;
            if (len_in == '0) result_q <= bias_in;
          end
        end
        ACCUM: begin
          if (fire) begin
            count_q <= count_q + LEN_BITS'(1);
            first_q <= 1'b0;
          end
        end
        // FMA output has updated on the edge that ended the final fire.
        SETTLE: result_q <= fma_out_in;
        DONE: ;
      endcase
    end
  end

  always_comb begin
    busy_out         = (state != IDLE);
    x_ready_out      = (state == ACCUM) & w_valid_in;
    w_ready_out      = (state == ACCUM) & x_valid_in;
    fma_a_out        = '0;
    fma_b_out        = '0;
    fma_c_out        = '0;
    fma_a_valid_out  = 1'b0;
    fma_b_valid_out  = 1'b0;
    fma_c_valid_out  = 1'b0;
    fma_compute_out  = 1'b0;
    result_valid_out = (state == DONE);
    result_out       = result_q;
    count_out        = count_q;
    if (fire) begin
      fma_a_out       = x_in;
      fma_b_out       = w_in;
      fma_a_valid_out = 1'b1;
      fma_b_valid_out = 1'b1;
      fma_compute_out = 1'b1;
      // Seed the accumulator with the bias only on the job's first pair.
      if (first_q) begin
        fma_c_out       = bias_q;
        fma_c_valid_out = 1'b1;
      end
    end
  end

endmodule
